// File: rtl/move_queue_pkg.sv
// Shared definitions for the move queue: move codes, face indices, FSM
// encoding and small helpers for classifying packed 4-bit move codes.
package move_queue_pkg;

  localparam logic [3:0] MV_PAD = 4'd0;
  localparam logic [3:0] MV_R   = 4'd2;
  localparam logic [3:0] MV_RI  = 4'd3;
  localparam logic [3:0] MV_U   = 4'd4;
  localparam logic [3:0] MV_UI  = 4'd5;
  localparam logic [3:0] MV_F   = 4'd6;
  localparam logic [3:0] MV_FI  = 4'd7;
  localparam logic [3:0] MV_L   = 4'd8;
  localparam logic [3:0] MV_LI  = 4'd9;
  localparam logic [3:0] MV_B   = 4'd10;
  localparam logic [3:0] MV_BI  = 4'd11;
  localparam logic [3:0] MV_D   = 4'd12;
  localparam logic [3:0] MV_DI  = 4'd13;

  localparam logic [2:0] FACE_RIGHT = 3'd0;
  localparam logic [2:0] FACE_UP    = 3'd1;
  localparam logic [2:0] FACE_FRONT = 3'd2;
  localparam logic [2:0] FACE_LEFT  = 3'd3;
  localparam logic [2:0] FACE_BACK  = 3'd4;
  localparam logic [2:0] FACE_DOWN  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  function automatic logic is_valid_move(input logic [3:0] c);
    return (c >= MV_R) && (c <= MV_DI);
  endfunction

  // Same face, opposite direction: the pair is a no-op on the cube.
  function automatic logic is_inverse(input logic [3:0] a, input logic [3:0] b);
    return is_valid_move(a) && is_valid_move(b) && (a[3:1] == b[3:1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Move FIFO with a second "pop from tail" port so the newest entry can be
// retracted when an inverse move arrives right behind it.
module move_fifo #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [3:0]    i_wdata,
  input  logic          i_pop_head,
  input  logic          i_pop_tail,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic [3:0]    o_head_rdata,
  output logic [3:0]    o_tail_rdata
);

  logic [3:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW-1:0] w_tail_idx;
  logic          w_do_push;
  logic          w_do_pop_head;
  logic          w_do_pop_tail;

  assign o_empty      = (r_wr_ptr == r_rd_ptr);
  assign o_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count      = r_wr_ptr - r_rd_ptr;
  assign w_tail_idx   = r_wr_ptr[AW-1:0] - AW'(1);
  assign o_head_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_tail_rdata = r_mem[w_tail_idx];

  assign w_do_push     = i_push && !o_full;
  assign w_do_pop_head = i_pop_head && !o_empty;
  // The tail may never be retracted if it is the entry leaving through the head.
  assign w_do_pop_tail = i_pop_tail && !o_empty && !(w_do_pop_head && (o_count == (AW+1)'(1)));

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end else if (w_do_pop_tail) begin
        r_wr_ptr <= r_wr_ptr - (AW+1)'(1);
      end
      if (w_do_pop_head) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/move_queue.sv
// Collects packed move batches into a FIFO (cancelling adjacent inverse pairs)
// and, once the solution is complete, dispatches moves one by one to the stepper.
module move_queue
  import move_queue_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int BATCH = 50
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_moves,
  input  logic [4*BATCH-1:0] seq,
  input  logic               seq_complete,
  output logic [3:0]         next_move,
  output logic               start_move,
  input  logic               move_done,
  output logic [7:0]         num_moves,
  output logic [7:0]         curr_step,
  output logic               seq_done,
  output logic               overflow,
  output logic [2:0]         dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (BATCH > 1) ? $clog2(BATCH) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [4*BATCH-1:0] r_seq;
  logic [SW-1:0]      r_slot;
  logic               r_arm;
  logic               r_move_done_d;
  logic [3:0]         r_next_move;
  logic               r_start_move;
  logic [7:0]         r_num_moves;
  logic [7:0]         r_curr_step;
  logic               r_overflow;

  logic               w_capture;
  logic [3:0]         w_nib;
  logic               w_nib_valid;
  logic               w_in_load;
  logic               w_cancel;
  logic               w_push;
  logic               w_pop_head;
  logic               w_rise;
  logic               w_retire;
  logic               w_full;
  logic               w_empty;
  logic [AW:0]        w_count;
  logic [3:0]         w_head;
  logic [3:0]         w_tail;

  assign w_nib       = r_seq[4*BATCH-1 -: 4];
  assign w_nib_valid = is_valid_move(w_nib);
  assign w_in_load   = (r_state == ST_LOAD);
  assign w_cancel    = w_in_load && w_nib_valid && (w_count != '0) && is_inverse(w_tail, w_nib);
  assign w_push      = w_in_load && w_nib_valid && !w_cancel;
  assign w_pop_head  = (r_state == ST_ISSUE) && !w_empty;
  assign w_rise      = move_done && !r_move_done_d;
  assign w_retire    = (r_state == ST_WAIT_DONE) && w_rise;

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_push       (w_push),
    .i_wdata      (w_nib),
    .i_pop_head   (w_pop_head),
    .i_pop_tail   (w_cancel),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_head_rdata (w_head),
    .o_tail_rdata (w_tail)
  );

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (new_moves) begin
          w_next_state = ST_LOAD;
          w_capture    = 1'b1;
        end else if (r_arm || seq_complete) begin
          w_next_state = w_empty ? ST_DONE : ST_ISSUE;
        end
      end
      ST_LOAD: begin
        if (r_slot == '0) begin
          w_next_state = (r_arm || seq_complete) ? ST_ISSUE : ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_next_state = w_empty ? ST_DONE : ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_rise) begin
          w_next_state = w_empty ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        if (new_moves) begin
          w_next_state = ST_LOAD;
          w_capture    = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_seq         <= '0;
      r_slot        <= '0;
      r_arm         <= 1'b0;
      r_move_done_d <= 1'b0;
      r_next_move   <= MV_PAD;
      r_start_move  <= 1'b0;
      r_num_moves   <= '0;
      r_curr_step   <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_move_done_d <= move_done;
      r_start_move  <= w_pop_head;
      if (w_capture) begin
        r_seq  <= seq;
        r_slot <= SW'(BATCH - 1);
      end else if (w_in_load) begin
        r_seq  <= r_seq << 4;
        r_slot <= r_slot - SW'(1);
      end
      // A completion request is held until loading finishes, then consumed on dispatch.
      if ((r_state == ST_IDLE || r_state == ST_LOAD) &&
          (w_next_state == ST_ISSUE || w_next_state == ST_DONE)) begin
        r_arm <= 1'b0;
      end else if (seq_complete && (r_state == ST_IDLE || r_state == ST_LOAD ||
                                    (r_state == ST_DONE && new_moves))) begin
        r_arm <= 1'b1;
      end
      if (w_pop_head) begin
        r_next_move <= w_head;
      end
      if (w_push && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_push && !w_full && (r_num_moves != 8'hFF)) begin
        r_num_moves <= r_num_moves + 8'd1;
      end else if ((w_cancel || w_retire) && (r_num_moves != 8'd0)) begin
        r_num_moves <= r_num_moves - 8'd1;
      end
      if (w_retire && (r_curr_step != 8'hFF)) begin
        r_curr_step <= r_curr_step + 8'd1;
      end
    end
  end

  assign next_move  = r_next_move;
  assign start_move = r_start_move;
  assign num_moves  = r_num_moves;
  assign curr_step  = r_curr_step;
  assign seq_done   = (r_state == ST_DONE);
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_move_queue.sv
// Bench for move_queue: directed scenarios plus randomized batches, checked
// against a list-based model of queued moves and a scoreboard of issued codes.
module tb_move_queue;

  localparam int DEPTH = 64;
  localparam int BATCH = 50;
  localparam int W     = 4 * BATCH;

  logic         clock = 1'b0;
  logic         reset;
  logic         new_moves;
  logic [W-1:0] seq;
  logic         seq_complete;
  logic [3:0]   next_move;
  logic         start_move;
  logic         move_done;
  logic [7:0]   num_moves;
  logic [7:0]   curr_step;
  logic         seq_done;
  logic         overflow;
  logic [2:0]   dbg_state;

  always #20 clock = ~clock;

  move_queue #(.DEPTH(DEPTH), .BATCH(BATCH)) dut (
    .clock        (clock),
    .reset        (reset),
    .new_moves    (new_moves),
    .seq          (seq),
    .seq_complete (seq_complete),
    .next_move    (next_move),
    .start_move   (start_move),
    .move_done    (move_done),
    .num_moves    (num_moves),
    .curr_step    (curr_step),
    .seq_done     (seq_done),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] model_q[$];
  logic [3:0] batch_q[$];
  int         exp_step = 0;
  logic       exp_ovf = 1'b0;
  int         start_cnt = 0;
  int         served = 0;
  bit         stepper_en = 1'b1;
  int         step_delay = 10;
  int         run_base = 0;
  int         run_expected = 0;
  logic [3:0] last_issued = 4'd0;
  logic [3:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every start pulse must carry the next expected move code.
  always @(negedge clock) begin
    if (start_move === 1'b1) begin
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected got next_move=%0d expected no start", next_move);
      end else begin
        mon_exp = exp_q.pop_front();
        if (next_move !== mon_exp) begin
          errors++;
          $display("FAIL issued_move got %0d expected %0d", next_move, mon_exp);
        end
      end
    end
  end

  // Stepper: raise move_done step_delay cycles after each start, hold briefly.
  initial begin
    move_done = 1'b0;
    forever begin
      @(negedge clock);
      if (stepper_en && served < start_cnt) begin
        served++;
        repeat (step_delay - 1) @(negedge clock);
        move_done = 1'b1;
        repeat (2) @(negedge clock);
        move_done = 1'b0;
      end
    end
  end

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] pad_code();
    case ($urandom_range(0, 3))
      0:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd14;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [W-1:0] pack_batch();
    logic [W-1:0] s;
    int n;
    n = batch_q.size();
    s = '0;
    for (int k = 0; k < BATCH; k++) begin
      if (k < n) s[4*k +: 4] = batch_q[n-1-k];
      else       s[4*k +: 4] = pad_code();
    end
    return s;
  endfunction

  // Reference: list of undispatched moves; an inverse arrival retracts the newest.
  task automatic model_batch();
    logic [3:0] m;
    logic [3:0] t;
    foreach (batch_q[i]) begin
      m = batch_q[i];
      if (m >= 4'd2 && m <= 4'd13) begin
        if (model_q.size() > 0) t = model_q[model_q.size()-1];
        else                    t = 4'd0;
        if (model_q.size() > 0 && t[3:1] == m[3:1] && t[0] != m[0]) void'(model_q.pop_back());
        else if (model_q.size() < DEPTH) model_q.push_back(m);
        else exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic pulse_new(input logic [W-1:0] s);
    @(negedge clock);
    seq = s;
    new_moves = 1'b1;
    @(negedge clock);
    new_moves = 1'b0;
  endtask

  task automatic send_batch();
    logic [W-1:0] s;
    s = pack_batch();
    model_batch();
    pulse_new(s);
    repeat (BATCH + 3) @(negedge clock);
  endtask

  task automatic check_load(input string tag);
    int sz;
    sz = (model_q.size() > 255) ? 255 : model_q.size();
    check({tag, "_num_moves_load"}, num_moves, sz);
    check({tag, "_overflow"}, overflow, exp_ovf);
  endtask

  task automatic arm();
    run_base     = start_cnt;
    run_expected = model_q.size();
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    if (run_expected > 0) last_issued = model_q[run_expected-1];
    exp_step = (exp_step + run_expected > 255) ? 255 : exp_step + run_expected;
    model_q.delete();
    @(negedge clock);
    seq_complete = 1'b1;
    @(negedge clock);
    seq_complete = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int t;
    t = 0;
    while (seq_done !== 1'b1 && t < 20000) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_seq_done"}, seq_done, 1);
    check({tag, "_starts"}, start_cnt - run_base, run_expected);
    check({tag, "_curr_step"}, curr_step, exp_step);
    check({tag, "_num_moves_end"}, num_moves, 0);
    check({tag, "_exp_q_empty"}, exp_q.size(), 0);
    if (run_expected > 0) check({tag, "_next_move_hold"}, next_move, last_issued);
    repeat (4) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    model_q.delete();
    exp_step = 0;
    exp_ovf  = 1'b0;
    served   = start_cnt;
  endtask

  task automatic wait_start(input string tag);
    int t;
    t = 0;
    while (start_cnt == run_base && t < 500) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_start_seen"}, start_cnt - run_base, 1);
  endtask

  initial begin
    logic [W-1:0] s;
    logic [3:0]   last;
    int           r;
    reset = 1'b1;
    new_moves = 1'b0;
    seq_complete = 1'b0;
    seq = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_next_move", next_move, 0);
    check("rst_start_move", start_move, 0);
    check("rst_num_moves", num_moves, 0);
    check("rst_curr_step", curr_step, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_overflow", overflow, 0);

    // {R,U,F}
    batch_q = '{4'd2, 4'd4, 4'd6};
    send_batch();
    check_load("basic");
    arm();
    finish_run("basic");

    // {R,U,Ui,Ri,F}: chained cancellation leaves F only
    do_reset();
    batch_q = '{4'd2, 4'd4, 4'd5, 4'd3, 4'd6};
    send_batch();
    check("chain_num_moves", num_moves, 1);
    arm();
    finish_run("chain");

    // {L,B} then {Bi,D}: cancel across batch boundary
    do_reset();
    batch_q = '{4'd8, 4'd10};
    send_batch();
    batch_q = '{4'd11, 4'd12};
    send_batch();
    check_load("cross");
    arm();
    finish_run("cross");

    // seq_complete during LOAD of {D,Di,R}
    do_reset();
    batch_q = '{4'd12, 4'd13, 4'd2};
    s = pack_batch();
    model_batch();
    pulse_new(s);
    repeat (10) @(negedge clock);
    arm();
    repeat (30) @(negedge clock);
    check("midload_no_start", start_cnt - run_base, 0);
    finish_run("midload");

    // 70 R moves overflow a 64-entry FIFO
    do_reset();
    step_delay = 3;
    batch_q.delete();
    repeat (50) batch_q.push_back(4'd2);
    send_batch();
    batch_q.delete();
    repeat (20) batch_q.push_back(4'd2);
    send_batch();
    check("ovf_flag", overflow, 1);
    check("ovf_num_moves", num_moves, 64);
    arm();
    finish_run("ovf");
    step_delay = 10;

    // move_done already high when waiting starts
    do_reset();
    stepper_en = 1'b0;
    move_done  = 1'b1;
    batch_q = '{4'd4};
    send_batch();
    arm();
    wait_start("held");
    repeat (20) @(negedge clock);
    check("held_no_advance_step", curr_step, 0);
    check("held_no_done", seq_done, 0);
    move_done = 1'b0;
    repeat (3) @(negedge clock);
    check("held_fall_no_step", curr_step, 0);
    move_done = 1'b1;
    repeat (3) @(negedge clock);
    check("held_rise_step", curr_step, 1);
    check("held_rise_done", seq_done, 1);
    check("held_next_move", next_move, 4);
    move_done = 1'b0;
    repeat (3) @(negedge clock);

    // Reset while waiting on the first of 5 queued moves
    do_reset();
    batch_q = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
    send_batch();
    arm();
    wait_start("rstmid");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rstmid_next_move", next_move, 0);
    check("rstmid_start_move", start_move, 0);
    check("rstmid_num_moves", num_moves, 0);
    check("rstmid_curr_step", curr_step, 0);
    check("rstmid_seq_done", seq_done, 0);
    check("rstmid_overflow", overflow, 0);
    reset = 1'b0;
    exp_q.delete();
    model_q.delete();
    exp_step = 0;
    exp_ovf = 1'b0;
    r = start_cnt;
    repeat (40) @(negedge clock);
    check("rstmid_no_restart", start_cnt - r, 0);
    served = start_cnt;
    stepper_en = 1'b1;

    // Randomized batches, padding sprinkled anywhere
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int b = 0; b < $urandom_range(1, 3); b++) begin
        batch_q.delete();
        last = 4'd0;
        for (int k = 0; k < $urandom_range(1, 30); k++) begin
          r = $urandom_range(0, 9);
          if (r < 2) begin
            batch_q.push_back(pad_code());
          end else if (r < 5 && last != 4'd0) begin
            batch_q.push_back(last ^ 4'd1);
            last = last ^ 4'd1;
          end else begin
            last = 4'($urandom_range(2, 13));
            batch_q.push_back(last);
          end
        end
        send_batch();
        check_load("rand");
      end
      arm();
      finish_run("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_queue.md
Name: move_queue

Overview:
- Sits between solving_algorithm and move_to_step in the cube-robot datapath.
- Collects batches of packed 4-bit move codes (up to 50 per 200-bit word) into an on-chip FIFO, cancelling adjacent inverse pairs as it goes.
- Once told the solution is complete, issues the moves one at a time to the stepper driver and waits for each move's completion handshake.
- Reports load and progress counts for the 7-segment display.

Parameters:
- DEPTH, 64, FIFO entries; power of two.
- BATCH, 50, move slots per input word; input width is 4*BATCH.

Ports:
- clock  in  1  25 MHz system clock.
- reset  in  1  synchronous, active-high.
- new_moves  in  1  one-cycle pulse: seq holds a valid batch.
- seq  in  4*BATCH  packed moves; right-justified; the highest non-padding nibble is the earliest move; seq[3:0] is the last move.
- seq_complete  in  1  one-cycle pulse: no more batches; begin dispatch.
- next_move  out  4  code of the move being issued or executing.
- start_move  out  1  one-cycle pulse to move_to_step.
- move_done  in  1  from move_to_step; completion is its rising edge.
- num_moves  out  8  entries currently queued plus the one in flight; saturates at 255.
- curr_step  out  8  moves completed since reset; saturates at 255.
- seq_done  out  1  level; all queued moves executed.
- overflow  out  1  sticky; a push was attempted while the FIFO was full.

Behaviour:
- Move codes:
  - Valid codes are 2..13. Face = code[3:1]; code[0] = inverse.
  - Codes 0, 1, 14 and 15 are padding and are skipped wherever they appear.
- Reset (synchronous, active-high):
  - Clears the FIFO, all counters and pending flags, and the move_done edge register.
  - Output reset values: next_move=0, start_move=0, num_moves=0, curr_step=0, seq_done=0, overflow=0.
  - Reset mid-move leaves the stepper to finish on its own; no start is reissued.
- FSM states: IDLE, LOAD, ISSUE, WAIT_DONE, DONE.
- IDLE:
  - new_moves: capture seq into a shift register, set slot index=BATCH-1, go to LOAD.
  - seq_complete (armed): go to ISSUE if the FIFO is non-empty, otherwise go to DONE.
  - new_moves and seq_complete in the same cycle: LOAD wins; arm stays pending.
- LOAD:
  - Examines one nibble per cycle, from slot BATCH-1 down to 0; exactly BATCH cycles per batch.
  - Padding: no action.
  - Push/pop rule:
    - If the FIFO has an undispatched tail entry T with T[3:1]==m[3:1] and T[0]!=m[0], pop T (cancel).
    - Otherwise push m.
    - A cancel never touches the entry in flight.
  - Push when full: drop the move and set overflow.
  - new_moves during LOAD is ignored.
  - seq_complete during LOAD latches a pending arm.
  - After slot 0: go to ISSUE if armed, otherwise go to IDLE.
- ISSUE:
  - Pop the head into next_move and pulse start_move for exactly 1 cycle.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - On a move_done rising edge (previous value registered each cycle): curr_step+1, then go to ISSUE if the FIFO is non-empty, otherwise go to DONE.
  - move_done already high on entry does not count; only a 0->1 transition completes the move.
- DONE:
  - seq_done=1; next_move holds the last issued code.
  - new_moves clears seq_done and starts LOAD; dispatch re-arms only on a new seq_complete.
- num_moves:
  - +1 per push, -1 per cancel, -1 on the move_done edge that retires a move.
  - Never wraps below 0.
- Back-to-back moves: ISSUE-to-ISSUE spacing is at least 2 cycles plus the stepper time.
- FIFO pointers are log2(DEPTH)+1 bits; full/empty decided by MSB compare, wrap-around by natural overflow.

Decomposition:
- Shared package holds:
  - move code constants (R=2 … Di=13, PAD=0);
  - face index constants (RIGHT=0, UP=1, FRONT=2, LEFT=3, BACK=4, DOWN=5);
  - FSM state encodings;
  - an is_valid_move function and an is_inverse(a,b) function.
- One sub-module, move_fifo:
  - synchronous LIFO-capable FIFO with push, pop_head, pop_tail, full, empty, count and tail_rdata;
  - pop_tail is qualified against the in-flight head.

Test Plan:
- Single batch {R,U,F} right-justified, then seq_complete, with a stepper model raising move_done 10 cycles after each start -> next_move sequence 2,4,6; three start pulses; curr_step=3; seq_done=1; num_moves=0.
- Batch {R,U,Ui,Ri,F} -> after 50 load cycles num_moves=1 (chained cancellations); dispatch issues only 6.
- Two batches {L,B} then {Bi,D}, then seq_complete -> B/Bi cancel across the batch boundary; issued sequence 8,12.
- seq_complete pulsed mid-LOAD of batch {D,Di,R} -> arm latched; after load only R (2) is issued; no start_move before LOAD ends.
- 70 R moves over two batches, DEPTH=64 -> overflow=1; num_moves=64; exactly 64 start pulses.
- move_done held high from the start of WAIT_DONE -> no advance until it falls and rises again.
- Reset asserted in WAIT_DONE with 5 moves queued -> next cycle all outputs are at their reset values and no further start_move is issued.
